dds_pwl_mc: RTL

Parametrised multi-channel direct digital synthesiser: time-multiplexes CH phase accumulators through one piecewise-linear sine engine, driven by a run-time-loadable quarter-wave coefficient LUT. Each channel has its own frequency control word and phase offset. It replaces the single-channel 16-bit sine pipeline and sits between the register interface that loads coefficients and the downstream modulator/DAC path.

---
 rtl/dds_pkg.sv | 35 +++
 rtl/dds_lut_ram.sv | 37 +++
 rtl/dds_pwl_mc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the multi-channel piecewise-linear DDS.
//   - parameter derivation helpers (fraction width, channel tag width)
//   - pipeline latency
//   - quadrant encoding of the two phase MSBs
//   - field offsets of the {c0, c1} LUT word
package dds_pkg;

  localparam int LATENCY = 4;

  // Two phase MSBs select the quarter of the sine period.
  typedef enum logic [1:0] {
    Q_RISE     = 2'b00,  // 0..pi/2     : +lut(r)
    Q_FALL     = 2'b01,  // pi/2..pi    : +lut(~r)
    Q_NEG_RISE = 2'b10,  // pi..3pi/2   : -lut(r)
    Q_NEG_FALL = 2'b11   // 3pi/2..2pi  : -lut(~r)
  } quad_e;

  function automatic int calc_frac_w(input int phase_w, input int seg_w);
    return phase_w - 2 - seg_w;
  endfunction

  function automatic int calc_cw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // LUT word is {c0, c1}: slope in the low half, base value in the high half.
  function automatic int lut_c1_lsb(input int out_w);
    return 0 * out_w;
  endfunction

  function automatic int lut_c0_lsb(input int out_w);
    return out_w;
  endfunction

endpackage

// File: rtl/dds_lut_ram.sv
// dds_lut_ram: quarter-wave coefficient store, 2^SEG_W words of DATA_W bits.
// Ports:
//   clk       clock
//   i_we      synchronous write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_re      read enable; read data register holds while low
//   i_raddr   read address
//   o_rdata   registered read data (one-cycle latency)
module dds_lut_ram #(
  parameter int SEG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [SEG_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [SEG_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**SEG_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset branch so it maps onto block RAM; coefficients
  // survive a reset and are only changed by writes.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    // Holding the read register while disabled keeps an in-flight sample's
    // coefficients stable across stalls and concurrent writes.
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dds_pwl_mc.sv
// dds_pwl_mc: CH-channel time-multiplexed DDS with a piecewise-linear sine
// engine fed from a run-time loadable quarter-wave coefficient LUT.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset (LUT contents are kept)
//   cen        active-low run enable
//   wen        active-low LUT write strobe; low also stalls the engine
//   index_wri  LUT write address
//   D          LUT write data {c0, c1}, both unsigned
//   fcw        per-channel frequency word, channel k at [k*PHASE_W +: PHASE_W]
//   offset     per-channel phase offset, same packing
//   sin_amp    signed sample
//   ch_out     channel tag of sin_amp
//   wen_out    one-cycle sample-valid strobe
// Pipeline: S0 phase accumulate, S1 fold + LUT read, S2 slope multiply,
// S3 add/saturate/sign -> outputs.
module dds_pwl_mc
  import dds_pkg::*;
#(
  parameter  int CH      = 4,
  parameter  int PHASE_W = 16,
  parameter  int SEG_W   = 6,
  parameter  int OUT_W   = 16,
  localparam int CW      = calc_cw(CH),
  localparam int FRAC_W  = calc_frac_w(PHASE_W, SEG_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cen,
  input  logic                    wen,
  input  logic [SEG_W-1:0]        index_wri,
  input  logic [2*OUT_W-1:0]      D,
  input  logic [CH*PHASE_W-1:0]   fcw,
  input  logic [CH*PHASE_W-1:0]   offset,
  output logic signed [OUT_W-1:0] sin_amp,
  output logic [CW-1:0]           ch_out,
  output logic                    wen_out
);

  localparam int C0_LSB = lut_c0_lsb(OUT_W);
  localparam int C1_LSB = lut_c1_lsb(OUT_W);
  localparam logic [OUT_W:0] SAT_MAX = {2'b00, {(OUT_W-1){1'b1}}};

  logic w_run;
  assign w_run = ~reset & ~cen & wen;

  // S0 state: accumulators and slot counter
  logic [PHASE_W-1:0] r_acc [CH];
  logic [CW-1:0]      r_slot;
  logic [PHASE_W-1:0] w_fcw_k, w_off_k;
  logic [PHASE_W-1:0] r_p0;
  logic [CW-1:0]      r_ch0;
  logic               r_v0;

  assign w_fcw_k = fcw[int'(r_slot)*PHASE_W +: PHASE_W];
  assign w_off_k = offset[int'(r_slot)*PHASE_W +: PHASE_W];

  // S1: quarter-wave fold of the registered phase
  quad_e              w_quad;
  logic               w_mirror, w_sign;
  logic [PHASE_W-3:0] w_r;
  logic [SEG_W-1:0]   w_seg;
  logic [FRAC_W-1:0]  w_frac;

  assign w_quad   = quad_e'(r_p0[PHASE_W-1 -: 2]);
  assign w_mirror = (w_quad == Q_FALL) || (w_quad == Q_NEG_FALL);
  assign w_sign   = (w_quad == Q_NEG_RISE) || (w_quad == Q_NEG_FALL);
  assign w_r      = w_mirror ? ~r_p0[PHASE_W-3:0] : r_p0[PHASE_W-3:0];
  assign w_seg    = w_r[PHASE_W-3 -: SEG_W];
  assign w_frac   = w_r[FRAC_W-1:0];

  logic [FRAC_W-1:0]  r_frac1;
  logic               r_sign1, r_v1;
  logic [CW-1:0]      r_ch1;
  logic [2*OUT_W-1:0] w_lut_q;
  logic [OUT_W-1:0]   w_c0, w_c1;

  dds_lut_ram #(
    .SEG_W  (SEG_W),
    .DATA_W (2*OUT_W)
  ) u_lut (
    .clk     (clk),
    .i_we    (~wen),
    .i_waddr (index_wri),
    .i_wdata (D),
    .i_re    (w_run),
    .i_raddr (w_seg),
    .o_rdata (w_lut_q)
  );

  assign w_c0 = w_lut_q[C0_LSB +: OUT_W];
  assign w_c1 = w_lut_q[C1_LSB +: OUT_W];

  // S2: slope * fraction
  logic [2*OUT_W-1:0] r_prod2;
  logic [OUT_W-1:0]   r_c0_2;
  logic               r_sign2, r_v2;
  logic [CW-1:0]      r_ch2;

  // S3: interpolate, saturate to the positive full scale, apply sign
  logic [OUT_W:0]   w_m;
  logic [OUT_W-1:0] w_mag;
  assign w_m   = {1'b0, r_c0_2} + (OUT_W+1)'(r_prod2 >> FRAC_W);
  assign w_mag = (w_m > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : w_m[OUT_W-1:0];

  logic [OUT_W-1:0] r_amp;
  logic [CW-1:0]    r_ch3;
  logic             r_wen_out;

  // NOTE: state is updated with non-blocking assignments so every stage reads
  // the previous cycle's value of the stage before it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CH; k++) r_acc[k] <= '0;
      r_slot    <= '0;
      r_p0      <= '0;
      r_ch0     <= '0;
      r_v0      <= 1'b0;
      r_frac1   <= '0;
      r_sign1   <= 1'b0;
      r_ch1     <= '0;
      r_v1      <= 1'b0;
      r_prod2   <= '0;
      r_c0_2    <= '0;
      r_sign2   <= 1'b0;
      r_ch2     <= '0;
      r_v2      <= 1'b0;
      r_amp     <= '0;
      r_ch3     <= '0;
      r_wen_out <= 1'b0;
    end else if (w_run) begin
      r_acc[r_slot] <= r_acc[r_slot] + w_fcw_k;
      r_slot        <= (r_slot == CW'(CH-1)) ? '0 : r_slot + 1'b1;
      r_p0          <= r_acc[r_slot] + w_off_k;
      r_ch0         <= r_slot;
      r_v0          <= 1'b1;

      r_frac1 <= w_frac;
      r_sign1 <= w_sign;
      r_ch1   <= r_ch0;
      r_v1    <= r_v0;

      r_prod2 <= (2*OUT_W)'(w_c1) * (2*OUT_W)'(r_frac1);
      r_c0_2  <= w_c0;
      r_sign2 <= r_sign1;
      r_ch2   <= r_ch1;
      r_v2    <= r_v1;

      r_wen_out <= r_v2;
      // Outputs only move on a real sample so they read 0 until the first one.
      if (r_v2) begin
        r_amp <= r_sign2 ? -w_mag : w_mag;
        r_ch3 <= r_ch2;
      end
    end else begin
      // Stalled: everything holds, only the strobe drops.
      r_wen_out <= 1'b0;
    end
  end

  assign sin_amp = r_amp;
  assign ch_out  = r_ch3;
  assign wen_out = r_wen_out;

endmodule
